// File: rtl/lisnoc_router_input_route_vc_pkg.sv
// Shared flit type encodings and sizing helpers for the input route stage.
// Optional malformed-flit checking is enabled with LISNOC_ROUTE_ERRCHK_EN.
package lisnoc_router_input_route_vc_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    // Index width needed to address a table of n destinations (at least 1 bit).
    function automatic int unsigned dest_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lisnoc_router_input_route_vc_chan.sv
// Single virtual channel: route lookup, packet route lock and one-entry output register.
// With LISNOC_ROUTE_ERRCHK_EN, orphan PAYLOAD/LAST and bad-destination headers are dropped.
module lisnoc_router_input_route_vc_chan
    import lisnoc_router_input_route_vc_pkg::*;
#(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned ph_dest_width   = 5,
    parameter int unsigned num_dests       = 32,
    parameter int unsigned directions      = 5,
    localparam int unsigned FlitWidth      = flit_data_width + flit_type_width
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FlitWidth-1:0]                  flit_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic [directions-1:0]                 read_i,
    input  logic [num_dests-1:0][directions-1:0]  lut_i,
    output logic [directions-1:0]                 req_o,
    output logic [FlitWidth-1:0]                  flit_o
`ifdef LISNOC_ROUTE_ERRCHK_EN
    ,
    output logic                                  route_err_o
`endif
);

    localparam int unsigned IdxW = dest_idx_width(num_dests);

    logic                    out_valid_q, out_valid_d;
    logic [FlitWidth-1:0]    out_flit_q, out_flit_d;
    logic [directions-1:0]   out_dir_q, out_dir_d;
    logic [directions-1:0]   lock_q, lock_d;
    logic                    in_pkt_q, in_pkt_d;

    logic [1:0]              ftype;
    logic [ph_dest_width-1:0] dest;
    logic                    dest_ok;
    logic [directions-1:0]   route;
    logic                    is_hdr;
    logic                    rd;
    logic                    accept;
    logic                    load;

    assign ftype   = flit_i[flit_data_width +: 2];
    assign dest    = flit_i[flit_data_width-1 -: ph_dest_width];
    assign dest_ok = 32'(dest) < num_dests;
    assign route   = dest_ok ? lut_i[dest[IdxW-1:0]] : '0;
    assign is_hdr  = (ftype == FLIT_TYPE_HEADER) || (ftype == FLIT_TYPE_SINGLE);

    // Ready never looks at valid_i, which keeps the FIFO handshake loop-free.
    assign rd      = out_valid_q & (|read_i);
    assign ready_o = ~out_valid_q | rd;
    assign accept  = ready_o & valid_i;

`ifdef LISNOC_ROUTE_ERRCHK_EN
    logic err;
    logic err_q;

    assign err  = accept & ((~is_hdr & ~in_pkt_q) | (is_hdr & ~dest_ok));
    assign load = accept & ~err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err;
        end
    end

    assign route_err_o = err_q;
`else
    assign load = accept;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_dir_d   = out_dir_q;
        lock_d      = lock_q;
        in_pkt_d    = in_pkt_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_flit_d  = flit_i;
            out_dir_d   = is_hdr ? route : lock_q;
            unique case (ftype)
                FLIT_TYPE_HEADER: begin
                    lock_d   = route;
                    in_pkt_d = 1'b1;
                end
                FLIT_TYPE_LAST,
                FLIT_TYPE_SINGLE: in_pkt_d = 1'b0;
                default: ;
            endcase
        end else if (rd) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_dir_q   <= '0;
            lock_q      <= '0;
            in_pkt_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_dir_q   <= out_dir_d;
            lock_q      <= lock_d;
            in_pkt_q    <= in_pkt_d;
        end
    end

    assign req_o  = out_valid_q ? out_dir_q : '0;
    assign flit_o = out_flit_q;

endmodule

// File: rtl/lisnoc_router_input_route_vc.sv
// Input-port routing stage: slices per-VC buses and unpacks the lookup table.
// Define LISNOC_ROUTE_ERRCHK_EN to add the per-VC route_err output.
module lisnoc_router_input_route_vc
    import lisnoc_router_input_route_vc_pkg::*;
#(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned ph_dest_width   = 5,
    parameter int unsigned num_dests       = 32,
    parameter int unsigned directions      = 5,
    parameter int unsigned vchannels       = 2,
    parameter logic [directions*num_dests-1:0] lookup = '0,
    localparam int unsigned flit_width     = flit_data_width + flit_type_width
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [vchannels*flit_width-1:0]     fifo_flit,
    input  logic [vchannels-1:0]                fifo_valid,
    output logic [vchannels-1:0]                fifo_ready,
    output logic [vchannels*directions-1:0]     switch_request,
    output logic [vchannels*flit_width-1:0]     switch_flit,
    input  logic [vchannels*directions-1:0]     switch_read
`ifdef LISNOC_ROUTE_ERRCHK_EN
    ,
    output logic [vchannels-1:0]                route_err
`endif
);

    logic [num_dests-1:0][directions-1:0] lut;

    // Destination 0 sits in the most-significant slice of the flat table.
    for (genvar d = 0; d < num_dests; d++) begin : g_lut
        assign lut[d] = lookup[(num_dests-1-d)*directions +: directions];
    end

    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        lisnoc_router_input_route_vc_chan #(
            .flit_data_width (flit_data_width),
            .flit_type_width (flit_type_width),
            .ph_dest_width   (ph_dest_width),
            .num_dests       (num_dests),
            .directions      (directions)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .flit_i      (fifo_flit[v*flit_width +: flit_width]),
            .valid_i     (fifo_valid[v]),
            .ready_o     (fifo_ready[v]),
            .read_i      (switch_read[v*directions +: directions]),
            .lut_i       (lut),
            .req_o       (switch_request[v*directions +: directions]),
            .flit_o      (switch_flit[v*flit_width +: flit_width])
`ifdef LISNOC_ROUTE_ERRCHK_EN
            ,
            .route_err_o (route_err[v])
`endif
        );
    end

endmodule

// File: tb/tb_lisnoc_router_input_route_vc.sv
// Directed table-driven bench for lisnoc_router_input_route_vc (2 VCs, 16 destinations).
// Also builds with LISNOC_ROUTE_ERRCHK_EN defined to cover the route_err path.
module tb_lisnoc_router_input_route_vc;

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 34;
    localparam int unsigned ND = 16;
    localparam int unsigned DIR = 5;
    localparam int unsigned VC = 2;

    // Destinations 0..5 routed, 6..15 unrouted; dest 5 has two bits set.
    localparam logic [DIR*ND-1:0] LUT = {5'b00001, 5'b00010, 5'b01000, 5'b00100,
                                         5'b10000, 5'b00011, {10{5'b00000}}};

    localparam logic [1:0] TP = 2'b00;
    localparam logic [1:0] TH = 2'b01;
    localparam logic [1:0] TL = 2'b10;
    localparam logic [1:0] TS = 2'b11;
    localparam logic [4:0] ALL = 5'b11111;

    logic                 clk;
    logic                 rst;
    logic [VC*FW-1:0]     fifo_flit;
    logic [VC-1:0]        fifo_valid;
    logic [VC-1:0]        fifo_ready;
    logic [VC*DIR-1:0]    switch_request;
    logic [VC*FW-1:0]     switch_flit;
    logic [VC*DIR-1:0]    switch_read;
`ifdef LISNOC_ROUTE_ERRCHK_EN
    logic [VC-1:0]        route_err;
`endif

    lisnoc_router_input_route_vc #(
        .flit_data_width (DW),
        .flit_type_width (2),
        .ph_dest_width   (5),
        .num_dests       (ND),
        .directions      (DIR),
        .vchannels       (VC),
        .lookup          (LUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_flit      (fifo_flit),
        .fifo_valid     (fifo_valid),
        .fifo_ready     (fifo_ready),
        .switch_request (switch_request),
        .switch_flit    (switch_flit),
        .switch_read    (switch_read)
`ifdef LISNOC_ROUTE_ERRCHK_EN
        ,
        .route_err      (route_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            v0;
        logic [FW-1:0]   f0;
        logic            v1;
        logic [FW-1:0]   f1;
        logic [4:0]      rd0;
        logic [4:0]      rd1;
        logic [1:0]      rdy;
        logic [4:0]      req0;
        logic [4:0]      req1;
    } vec_t;

    int total = 0;
    int bad = 0;
    vec_t tbl[25];

    function automatic logic [FW-1:0] fl(input logic [1:0] t, input int d, input int tag);
        logic [4:0]  dd;
        logic [26:0] tt;
        dd = d[4:0];
        tt = tag[26:0];
        return {t, dd, tt};
    endfunction

    function automatic vec_t mk(input logic v0, input logic [FW-1:0] f0, input logic v1,
                                input logic [FW-1:0] f1, input logic [4:0] rd0,
                                input logic [4:0] rd1, input logic [1:0] rdy,
                                input logic [4:0] req0, input logic [4:0] req1);
        vec_t r;
        r.v0 = v0; r.f0 = f0; r.v1 = v1; r.f1 = f1;
        r.rd0 = rd0; r.rd1 = rd1; r.rdy = rdy; r.req0 = req0; r.req1 = req1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [FW-1:0] f0, input logic v1,
                         input logic [FW-1:0] f1, input logic [4:0] rd0, input logic [4:0] rd1);
        fifo_valid  = {v1, v0};
        fifo_flit   = {f1, f0};
        switch_read = {rd1, rd0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [FW-1:0] z;
    logic [FW-1:0] cur0;

    initial begin
        z = '0;
        cur0 = '0;
        rst = 1'b0;
        drive(1'b0, z, 1'b0, z, 5'b0, 5'b0);
        repeat (3) tick();
        chk("reset_ready", 64'(fifo_ready), 64'(2'b11));
        chk("reset_req", 64'(switch_request), 64'd0);
        chk("reset_flit", 64'(switch_flit), 64'd0);
`ifdef LISNOC_ROUTE_ERRCHK_EN
        chk("reset_err", 64'(route_err), 64'd0);
`endif
        rst = 1'b1;

        // Streaming packet, stall/resume, interleaved VCs, multi-bit entry, back-to-back singles,
        // and a header restarting an open packet.
        tbl[0]  = mk(1, fl(TH, 3, 1),  0, z, ALL, 0, 2'b11, 5'b00100, 0);
        tbl[1]  = mk(1, fl(TP, 9, 2),  0, z, ALL, 0, 2'b11, 5'b00100, 0);
        tbl[2]  = mk(1, fl(TP, 9, 3),  0, z, ALL, 0, 2'b11, 5'b00100, 0);
        tbl[3]  = mk(1, fl(TL, 9, 4),  0, z, ALL, 0, 2'b11, 5'b00100, 0);
        tbl[4]  = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);
        tbl[5]  = mk(1, fl(TS, 1, 5),  0, z, 0,   0, 2'b11, 5'b00010, 0);
        tbl[6]  = mk(1, fl(TS, 4, 6),  0, z, 0,   0, 2'b10, 5'b00010, 0);
        tbl[7]  = mk(1, fl(TS, 4, 6),  0, z, 0,   0, 2'b10, 5'b00010, 0);
        tbl[8]  = mk(1, fl(TS, 4, 6),  0, z, 0,   0, 2'b10, 5'b00010, 0);
        tbl[9]  = mk(1, fl(TS, 4, 6),  0, z, 5'b00010, 0, 2'b11, 5'b10000, 0);
        tbl[10] = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);
        tbl[11] = mk(1, fl(TH, 0, 7),  1, fl(TS, 4, 8), 0, 0, 2'b11, 5'b00001, 5'b10000);
        tbl[12] = mk(1, fl(TP, 9, 9),  0, z, 0,   ALL, 2'b10, 5'b00001, 0);
        tbl[13] = mk(1, fl(TP, 9, 9),  0, z, ALL, 0, 2'b11, 5'b00001, 0);
        tbl[14] = mk(1, fl(TL, 9, 10), 0, z, ALL, 0, 2'b11, 5'b00001, 0);
        tbl[15] = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);
        tbl[16] = mk(1, fl(TS, 5, 11), 0, z, ALL, 0, 2'b11, 5'b00011, 0);
        tbl[17] = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);
        tbl[18] = mk(1, fl(TS, 1, 12), 0, z, ALL, 0, 2'b11, 5'b00010, 0);
        tbl[19] = mk(1, fl(TS, 2, 13), 0, z, ALL, 0, 2'b11, 5'b01000, 0);
        tbl[20] = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);
        tbl[21] = mk(1, fl(TH, 3, 14), 0, z, ALL, 0, 2'b11, 5'b00100, 0);
        tbl[22] = mk(1, fl(TH, 1, 15), 0, z, ALL, 0, 2'b11, 5'b00010, 0);
        tbl[23] = mk(1, fl(TL, 9, 16), 0, z, ALL, 0, 2'b11, 5'b00010, 0);
        tbl[24] = mk(0, z,             0, z, ALL, 0, 2'b11, 5'b00000, 0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v0, tbl[i].f0, tbl[i].v1, tbl[i].f1, tbl[i].rd0, tbl[i].rd1);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(fifo_ready), 64'(tbl[i].rdy));
            if (tbl[i].v0 && tbl[i].rdy[0]) cur0 = tbl[i].f0;
            tick();
            chk($sformatf("vec%0d_req0", i), 64'(switch_request[4:0]), 64'(tbl[i].req0));
            chk($sformatf("vec%0d_req1", i), 64'(switch_request[9:5]), 64'(tbl[i].req1));
            if (tbl[i].req0 != 5'b0)
                chk($sformatf("vec%0d_flit0", i), 64'(switch_flit[FW-1:0]), 64'(cur0));
        end

        // Reset in the middle of a packet, then an orphan PAYLOAD.
        drive(1, fl(TH, 3, 20), 0, z, ALL, 0);
        tick();
        chk("midrst_hdr_req", 64'(switch_request[4:0]), 64'(5'b00100));
        drive(0, z, 0, z, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_req", 64'(switch_request), 64'd0);
        chk("midrst_ready", 64'(fifo_ready), 64'(2'b11));
        drive(1, fl(TP, 9, 21), 0, z, 0, 0);
        @(negedge clk);
        chk("orphan_pop", 64'(fifo_ready[0]), 64'd1);
        tick();
        chk("orphan_req", 64'(switch_request[4:0]), 64'd0);
`ifdef LISNOC_ROUTE_ERRCHK_EN
        chk("orphan_err", 64'(route_err), 64'(2'b01));
`endif
        drive(0, z, 0, z, 0, 0);
        @(negedge clk);
`ifdef LISNOC_ROUTE_ERRCHK_EN
        chk("orphan_dropped", 64'(fifo_ready[0]), 64'd1);
        tick();
        chk("orphan_err_pulse", 64'(route_err), 64'd0);
`else
        chk("orphan_held", 64'(fifo_ready[0]), 64'd0);
        drive(0, z, 0, z, ALL, 0);
        tick();
`endif

        // Header with destination beyond the table.
        drive(1, fl(TH, 20, 22), 0, z, 0, 0);
        @(negedge clk);
        chk("baddest_pop", 64'(fifo_ready[0]), 64'd1);
        tick();
        chk("baddest_req", 64'(switch_request[4:0]), 64'd0);
`ifdef LISNOC_ROUTE_ERRCHK_EN
        chk("baddest_err", 64'(route_err), 64'(2'b01));
`endif
        drive(0, z, 0, z, 0, 0);
        @(negedge clk);
`ifdef LISNOC_ROUTE_ERRCHK_EN
        chk("baddest_dropped", 64'(fifo_ready[0]), 64'd1);
        tick();
        chk("baddest_err_pulse", 64'(route_err), 64'd0);
`else
        chk("baddest_held", 64'(fifo_ready[0]), 64'd0);
        drive(0, z, 0, z, ALL, 0);
        tick();
`endif
        drive(1, fl(TH, 1, 23), 0, z, ALL, 0);
        tick();
        chk("after_bad_req", 64'(switch_request[4:0]), 64'(5'b00010));
        chk("after_bad_flit", 64'(switch_flit[FW-1:0]), 64'(fl(TH, 1, 23)));
        drive(1, fl(TL, 9, 24), 0, z, ALL, 0);
        tick();
        chk("after_bad_last", 64'(switch_request[4:0]), 64'(5'b00010));
        drive(0, z, 0, z, ALL, 0);
        tick();
        chk("final_idle", 64'(switch_request), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
